// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the parameterised register file.
// Optional write-through forwarding is enabled with macro REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int RF_DATA_W_DEF = 64;
    localparam int RF_ADDR_W_DEF = 5;
    localparam int RF_N_RD_DEF   = 2;

    typedef enum logic {
        RF_INIT  = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_if.sv
// Write/read bus of the register file; master drives addresses and write data.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W_DEF,
    parameter int ADDR_W = RF_ADDR_W_DEF,
    parameter int N_RD   = RF_N_RD_DEF
);
    logic                         we3;
    logic [ADDR_W-1:0]            wa3;
    logic [DATA_W-1:0]            wd3;
    logic [N_RD-1:0][ADDR_W-1:0]  ra;
    logic [N_RD-1:0][DATA_W-1:0]  rd;
    logic                         busy;

    modport master (
        output we3, wa3, wd3, ra,
        input  rd, busy
    );

    modport slave (
        input  we3, wa3, wd3, ra,
        output rd, busy
    );
endinterface

// File: rtl/regfile_init_ctrl.sv
// Post-reset init walk: writes reg[n] = n for n = 0..DEPTH-2, holding busy high meanwhile.
module regfile_init_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              o_busy,
    output logic              o_init_we,
    output logic [ADDR_W-1:0] o_init_addr
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 2);

    rf_state_t         r_state;
    logic              r_busy;
    logic [ADDR_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RF_INIT;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RF_INIT: begin
                    // The edge that writes the last storage slot also ends the walk.
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= RF_READY;
                        r_busy  <= 1'b0;
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                    r_state <= RF_READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_init_we   = r_busy;
    assign o_init_addr = r_cnt;
endmodule

// File: rtl/regfile_param.sv
// Multi-read, single-write register file with a hard-wired zero register at DEPTH-1.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W_DEF,
    parameter int ADDR_W = RF_ADDR_W_DEF,
    parameter int N_RD   = RF_N_RD_DEF
) (
    input logic       clk,
    input logic       reset,
    regfile_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(DEPTH - 1);

    logic                        w_busy;
    logic                        w_init_we;
    logic [ADDR_W-1:0]           w_init_addr;
    logic                        w_user_we;
    logic [DATA_W-1:0]           r_mem [DEPTH-1];
    logic [N_RD-1:0][DATA_W-1:0] w_rd;

    function automatic logic [DATA_W-1:0] zext_addr(input logic [ADDR_W-1:0] a);
        return DATA_W'(a);
    endfunction

    regfile_init_ctrl #(
        .ADDR_W(ADDR_W)
    ) u_init_ctrl (
        .clk         (clk),
        .reset       (reset),
        .o_busy      (w_busy),
        .o_init_we   (w_init_we),
        .o_init_addr (w_init_addr)
    );

    assign w_user_we = bus.we3 && !w_busy && (bus.wa3 != ZERO_ADDR);

    // Storage carries no reset; contents become defined only through the init walk.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_init_we) begin
                r_mem[w_init_addr] <= zext_addr(w_init_addr);
            end else if (w_user_we) begin
                r_mem[bus.wa3] <= bus.wd3;
            end
        end
    end

    // Busy masking and the zero register override any forwarding.
    always_comb begin
        w_rd = '0;
        for (int p = 0; p < N_RD; p++) begin
            if (w_busy || bus.ra[p] == ZERO_ADDR) begin
                w_rd[p] = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (w_user_we && bus.wa3 == bus.ra[p]) begin
                w_rd[p] = bus.wd3;
`endif
            end else begin
                w_rd[p] = r_mem[bus.ra[p]];
            end
        end
    end

    assign bus.rd   = w_rd;
    assign bus.busy = w_busy;
endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (DATA_W=64, ADDR_W=5, N_RD=2).
module tb_regfile_param;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int N_RD   = 2;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD)) bus ();

    regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [63:0] exp64;
        int n;
        reset = 1'b0;
        bus.we3 = 1'b1;
        bus.wa3 = 5'd0;
        bus.wd3 = 64'd77;
        bus.ra[0] = 5'd0;
        bus.ra[1] = 5'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy got=%0b exp=1", bus.busy);
        end
        exp64 = 64'd0;
        checks++;
        if (bus.rd[0] !== exp64 || bus.rd[1] !== exp64) begin
            errors++;
            $display("FAIL reset_rd_masked got=%0h/%0h exp=0", bus.rd[0], bus.rd[1]);
        end
        bus.we3 = 1'b0;
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 5) begin
                checks++;
                if (bus.rd[0] !== 64'd0) begin
                    errors++;
                    $display("FAIL walk_rd_masked got=%0h exp=0", bus.rd[0]);
                end
            end
            if (bus.busy !== 1'b1) break;
        end
        checks++;
        if (n != 31 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL init_walk_len got=%0d busy=%0b exp=31 busy=0", n, bus.busy);
        end
    endtask

    task automatic test_init_values();
        logic [63:0] e0, e1;
        for (int a = 0; a <= 30; a++) begin
            bus.ra[0] = 5'(a);
            bus.ra[1] = 5'(30 - a);
            #1;
            e0 = 64'(a);
            e1 = 64'(30 - a);
            checks++;
            if (bus.rd[0] !== e0 || bus.rd[1] !== e1) begin
                errors++;
                $display("FAIL init_value a=%0d got=%0h/%0h exp=%0h/%0h", a, bus.rd[0], bus.rd[1], e0, e1);
            end
        end
        bus.ra[0] = 5'd31;
        bus.ra[1] = 5'd31;
        #1;
        checks++;
        if (bus.rd[0] !== 64'd0 || bus.rd[1] !== 64'd0) begin
            errors++;
            $display("FAIL init_zero_reg got=%0h/%0h exp=0", bus.rd[0], bus.rd[1]);
        end
    endtask

    task automatic test_write();
        @(posedge clk);
        #1;
        bus.we3 = 1'b1;
        bus.wa3 = 5'd7;
        bus.wd3 = 64'hDEAD_BEEF_0000_0001;
        @(posedge clk);
        #1;
        bus.we3 = 1'b0;
        bus.ra[0] = 5'd7;
        bus.ra[1] = 5'd7;
        #1;
        checks++;
        if (bus.rd[0] !== 64'hDEAD_BEEF_0000_0001 || bus.rd[1] !== 64'hDEAD_BEEF_0000_0001) begin
            errors++;
            $display("FAIL write_x7 got=%0h/%0h exp=deadbeef00000001", bus.rd[0], bus.rd[1]);
        end
        bus.ra[0] = 5'd31;
        #1;
        checks++;
        if (bus.rd[0] !== 64'd0 || bus.rd[1] !== 64'hDEAD_BEEF_0000_0001) begin
            errors++;
            $display("FAIL write_zero_mix got=%0h/%0h exp=0/deadbeef00000001", bus.rd[0], bus.rd[1]);
        end
    endtask

    task automatic test_zero_write();
        logic [63:0] e;
        @(posedge clk);
        #1;
        bus.we3 = 1'b1;
        bus.wa3 = 5'd31;
        bus.wd3 = 64'd1;
        bus.ra[0] = 5'd31;
        bus.ra[1] = 5'd31;
        #1;
        checks++;
        if (bus.rd[0] !== 64'd0 || bus.rd[1] !== 64'd0) begin
            errors++;
            $display("FAIL zero_bypass got=%0h/%0h exp=0", bus.rd[0], bus.rd[1]);
        end
        @(posedge clk);
        #1;
        bus.we3 = 1'b0;
        checks++;
        if (bus.rd[0] !== 64'd0 || bus.rd[1] !== 64'd0) begin
            errors++;
            $display("FAIL zero_after_write got=%0h/%0h exp=0", bus.rd[0], bus.rd[1]);
        end
        for (int a = 0; a <= 30; a++) begin
            bus.ra[1] = 5'(a);
            #1;
            e = (a == 7) ? 64'hDEAD_BEEF_0000_0001 : 64'(a);
            checks++;
            if (bus.rd[1] !== e) begin
                errors++;
                $display("FAIL zero_unchanged a=%0d got=%0h exp=%0h", a, bus.rd[1], e);
            end
        end
    endtask

    task automatic test_reset_midwalk();
        int n;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midwalk_busy got=%0b exp=1", bus.busy);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (n == 2) begin
                bus.we3 = 1'b1;
                bus.wa3 = 5'd3;
                bus.wd3 = 64'd5;
            end else begin
                bus.we3 = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (bus.busy !== 1'b1) break;
        end
        bus.we3 = 1'b0;
        checks++;
        if (n != 31 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_walk_len got=%0d busy=%0b exp=31 busy=0", n, bus.busy);
        end
        bus.ra[0] = 5'd3;
        bus.ra[1] = 5'd7;
        #1;
        checks++;
        if (bus.rd[0] !== 64'd3 || bus.rd[1] !== 64'd7) begin
            errors++;
            $display("FAIL restart_values got=%0h/%0h exp=3/7", bus.rd[0], bus.rd[1]);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 64'd99;
`else
        exp_pre = 64'd4;
`endif
        @(posedge clk);
        #1;
        bus.ra[0] = 5'd4;
        bus.ra[1] = 5'd5;
        bus.we3 = 1'b1;
        bus.wa3 = 5'd4;
        bus.wd3 = 64'd99;
        #1;
        checks++;
        if (bus.rd[0] !== exp_pre || bus.rd[1] !== 64'd5) begin
            errors++;
            $display("FAIL bypass_pre got=%0h/%0h exp=%0h/5", bus.rd[0], bus.rd[1], exp_pre);
        end
        @(posedge clk);
        #1;
        bus.we3 = 1'b0;
        #1;
        checks++;
        if (bus.rd[0] !== 64'd99) begin
            errors++;
            $display("FAIL bypass_post got=%0h exp=99", bus.rd[0]);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        bus.we3 = 1'b0;
        bus.wa3 = '0;
        bus.wd3 = '0;
        bus.ra = '0;
        test_reset();
        test_init_values();
        test_write();
        test_zero_write();
        test_reset_midwalk();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
